// File: rtl/present_decrypt_iter.sv
// Iterative PRESENT-80 decryption core: key schedule is run forward to the last
// round key, then one inverse round per clock while the key register is rolled back.
module present_decrypt_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [79:0] key,
  input  logic [63:0] ct,
  output logic        busy,
  output logic        valid,
  output logic [63:0] pt
);

  typedef enum logic [1:0] {IDLE, KEYEXP, WHITEN, DECRYPT} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [4:0]  r_rc;
  logic [63:0] r_st;
  logic [79:0] r_kr;
  logic        r_busy;
  logic        r_valid;
  logic [63:0] r_pt;

  function automatic logic [3:0] f_sbox(input logic [3:0] x);
    case (x)
      4'h0: f_sbox = 4'hC;  4'h1: f_sbox = 4'h5;  4'h2: f_sbox = 4'h6;  4'h3: f_sbox = 4'hB;
      4'h4: f_sbox = 4'h9;  4'h5: f_sbox = 4'h0;  4'h6: f_sbox = 4'hA;  4'h7: f_sbox = 4'hD;
      4'h8: f_sbox = 4'h3;  4'h9: f_sbox = 4'hE;  4'hA: f_sbox = 4'hF;  4'hB: f_sbox = 4'h8;
      4'hC: f_sbox = 4'h4;  4'hD: f_sbox = 4'h7;  4'hE: f_sbox = 4'h1;  default: f_sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] f_inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: f_inv_sbox = 4'h5;  4'h1: f_inv_sbox = 4'hE;  4'h2: f_inv_sbox = 4'hF;  4'h3: f_inv_sbox = 4'h8;
      4'h4: f_inv_sbox = 4'hC;  4'h5: f_inv_sbox = 4'h1;  4'h6: f_inv_sbox = 4'h2;  4'h7: f_inv_sbox = 4'hD;
      4'h8: f_inv_sbox = 4'hB;  4'h9: f_inv_sbox = 4'h4;  4'hA: f_inv_sbox = 4'h6;  4'hB: f_inv_sbox = 4'h3;
      4'hC: f_inv_sbox = 4'h0;  4'hD: f_inv_sbox = 4'h7;  4'hE: f_inv_sbox = 4'h9;  default: f_inv_sbox = 4'hA;
    endcase
  endfunction

  // Forward key update used while walking up to round key 32
  logic [79:0] w_kr_rot;
  logic [79:0] w_kf;
  assign w_kr_rot = {r_kr[18:0], r_kr[79:19]};
  assign w_kf     = {f_sbox(w_kr_rot[79:76]), w_kr_rot[75:20], w_kr_rot[19:15] ^ r_rc, w_kr_rot[14:0]};

  // Inverse key update: undo counter XOR, undo S-box, rotate right by 61 (= left by 19)
  logic [79:0] w_kx;
  logic [79:0] w_ks;
  logic [79:0] w_kp;
  assign w_kx = {r_kr[79:20], r_kr[19:15] ^ r_rc, r_kr[14:0]};
  assign w_ks = {f_inv_sbox(w_kx[79:76]), w_kx[75:0]};
  assign w_kp = {w_ks[60:0], w_ks[79:61]};

  logic [63:0] w_invp;
  logic [63:0] w_invs;
  logic [63:0] w_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 63; gi++) begin : g_invp
      assign w_invp[(4 * gi) % 63] = r_st[gi];
    end
    for (gi = 0; gi < 16; gi++) begin : g_invs
      assign w_invs[4*gi +: 4] = f_inv_sbox(w_invp[4*gi +: 4]);
    end
  endgenerate
  assign w_invp[63] = r_st[63];
  assign w_dec      = w_invs ^ w_kp[79:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = KEYEXP;
      KEYEXP:  if (r_rc == 5'd31) w_state_next = WHITEN;
      WHITEN:  w_state_next = DECRYPT;
      DECRYPT: if (r_rc == 5'd1) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc    <= 5'd0;
      r_st    <= 64'd0;
      r_kr    <= 80'd0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_pt    <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_kr    <= key;
            r_st    <= ct;
            r_rc    <= 5'd1;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        KEYEXP: begin
          r_kr <= w_kf;
          // Hold at 31 so the counter never wraps to 0
          if (r_rc != 5'd31) r_rc <= r_rc + 5'd1;
        end
        WHITEN: begin
          r_st <= r_st ^ r_kr[79:16];
          r_rc <= 5'd31;
        end
        DECRYPT: begin
          r_st <= w_dec;
          r_kr <= w_kp;
          if (r_rc == 5'd1) begin
            r_pt    <= w_dec;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_rc <= r_rc - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = r_busy;
  assign valid = r_valid;
  assign pt    = r_pt;

endmodule

// File: tb/tb_present_decrypt_iter.sv
// Directed and model-based checks of the iterative PRESENT-80 decryption core.
module tb_present_decrypt_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [79:0] key = '0;
  logic [63:0] ct = '0;
  logic        busy;
  logic        valid;
  logic [63:0] pt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  present_decrypt_iter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .key   (key),
    .ct    (ct),
    .busy  (busy),
    .valid (valid),
    .pt    (pt)
  );

  function automatic logic [3:0] sb(input logic [3:0] x);
    case (x)
      4'h0: sb = 4'hC;  4'h1: sb = 4'h5;  4'h2: sb = 4'h6;  4'h3: sb = 4'hB;
      4'h4: sb = 4'h9;  4'h5: sb = 4'h0;  4'h6: sb = 4'hA;  4'h7: sb = 4'hD;
      4'h8: sb = 4'h3;  4'h9: sb = 4'hE;  4'hA: sb = 4'hF;  4'hB: sb = 4'h8;
      4'hC: sb = 4'h4;  4'hD: sb = 4'h7;  4'hE: sb = 4'h1;  default: sb = 4'h2;
    endcase
  endfunction

  // Golden PRESENT-80 encryption
  function automatic logic [63:0] present_enc(input logic [79:0] k_in, input logic [63:0] p);
    logic [79:0] k;
    logic [63:0] s;
    logic [63:0] t;
    k = k_in;
    s = p;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int j = 0; j < 16; j++) t[4*j +: 4] = sb(s[4*j +: 4]);
      for (int b = 0; b < 63; b++) s[(16 * b) % 63] = t[b];
      s[63] = t[63];
      k = {k[18:0], k[79:19]};
      k[79:76] = sb(k[79:76]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  // Present a start pulse; returns at the negedge just after the accepting edge
  task automatic issue(input logic [79:0] k, input logic [63:0] c);
    @(negedge clk);
    key   = k;
    ct    = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (pt !== 64'd0)   begin errors++; $display("FAIL reset_pt: got %h expected 0", pt); end
    $display("reset: busy=%b valid=%b pt=%h", busy, valid, pt);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors;
    logic [79:0] kv [3];
    logic [63:0] cv [3];
    logic [63:0] pv [3];
    int n;
    kv[0] = 80'h0;                    cv[0] = 64'h5579C1387B228445; pv[0] = 64'h0;
    kv[1] = 80'hFFFFFFFFFFFFFFFFFFFF; cv[1] = 64'hE72C46C0F5945049; pv[1] = 64'h0;
    kv[2] = 80'hFFFFFFFFFFFFFFFFFFFF; cv[2] = 64'h3333DCD3213210D2; pv[2] = 64'hFFFFFFFFFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      issue(kv[i], cv[i]);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL vec%0d_busy: got %b expected 1", i, busy); end
      wait_valid(n);
      $display("vector %0d: key=%h ct=%h pt=%h latency=%0d", i, kv[i], cv[i], pt, n);
      checks++; if (n !== 63)      begin errors++; $display("FAIL vec%0d_latency: got %0d expected 63", i, n); end
      checks++; if (pt !== pv[i])  begin errors++; $display("FAIL vec%0d_pt: got %h expected %h", i, pt, pv[i]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_done: got %b expected 0", i, busy); end
      repeat (3) @(negedge clk);
      checks++; if (valid !== 1'b1 || pt !== pv[i]) begin
        errors++; $display("FAIL vec%0d_hold: got valid=%b pt=%h expected valid=1 pt=%h", i, valid, pt, pv[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int n2;
    issue(80'h0, 64'h5579C1387B228445);
    wait_valid(n);
    checks++; if (pt !== 64'h0) begin errors++; $display("FAIL b2b_first_pt: got %h expected 0", pt); end
    key   = 80'h0;
    ct    = 64'hA112FFC72F68417B;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_clear: got %b expected 0", valid); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL b2b_busy: got %b expected 1", busy); end
    checks++; if (pt !== 64'h0)   begin errors++; $display("FAIL b2b_pt_held: got %h expected 0", pt); end
    wait_valid(n2);
    $display("back_to_back: first latency=%0d second pt=%h gap=%0d", n, pt, n2 + 1);
    checks++; if (n2 + 1 !== 64) begin errors++; $display("FAIL b2b_gap: got %0d expected 64", n2 + 1); end
    checks++; if (pt !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL b2b_second_pt: got %h expected ffffffffffffffff", pt); end
  endtask

  task automatic test_ignore_start;
    int n;
    issue(80'h0, 64'hA112FFC72F68417B);
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 5 || n == 40) begin
        key   = {$urandom(), $urandom(), 16'($urandom())};
        ct    = {$urandom(), $urandom()};
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    $display("ignore_start: pt=%h latency=%0d", pt, n);
    checks++; if (n !== 63) begin errors++; $display("FAIL ignore_latency: got %0d expected 63", n); end
    checks++; if (pt !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL ignore_pt: got %h expected ffffffffffffffff", pt); end
  endtask

  task automatic test_reset_mid;
    int n;
    int seen;
    issue(80'hFFFFFFFFFFFFFFFFFFFF, 64'h3333DCD3213210D2);
    repeat (45) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || valid !== 1'b0 || pt !== 64'd0) begin
      errors++; $display("FAIL midreset_outputs: got busy=%b valid=%b pt=%h expected all 0", busy, valid, pt);
    end
    key   = 80'h0;
    ct    = 64'h5579C1387B228445;
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (valid || busy) seen++;
    end
    $display("mid_reset: cycles with busy/valid after release=%0d", seen);
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); end
    issue(80'h0, 64'hA112FFC72F68417B);
    wait_valid(n);
    $display("after_reset: pt=%h latency=%0d", pt, n);
    checks++; if (n !== 63) begin errors++; $display("FAIL midreset_latency: got %0d expected 63", n); end
    checks++; if (pt !== 64'hFFFFFFFFFFFFFFFF) begin errors++; $display("FAIL midreset_pt: got %h expected ffffffffffffffff", pt); end
  endtask

  task automatic test_sweep;
    logic [79:0] k;
    logic [63:0] p;
    logic [63:0] c;
    int n;
    for (int i = 0; i < 4; i++) begin
      k = {$urandom(), $urandom(), 16'($urandom())};
      p = {$urandom(), $urandom()};
      c = present_enc(k, p);
      issue(k, c);
      wait_valid(n);
      $display("sweep %0d: key=%h ct=%h pt=%h latency=%0d", i, k, c, pt, n);
      checks++; if (n !== 63) begin errors++; $display("FAIL sweep%0d_latency: got %0d expected 63", i, n); end
      checks++; if (pt !== p) begin errors++; $display("FAIL sweep%0d_pt: got %h expected %h", i, pt, p); end
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_back_to_back;
    test_ignore_start;
    test_reset_mid;
    test_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
